// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder.
package mem_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

    localparam logic [3:0]  BE_WORD = 4'hF;
    localparam logic [3:0]  BE_NONE = 4'h0;
    localparam int unsigned LAT_W   = 4;

    // A request is rejected when it points past the array, enables no lanes, or asks for a
    // full word at an unaligned byte address.
    function automatic logic req_error(input logic [31:0] addr, input logic [3:0] be,
                                       input int unsigned depth);
        logic [31:0] idx;
        idx = {2'b00, addr[31:2]};
        return (idx >= depth) || (be == BE_NONE) || ((be == BE_WORD) && (addr[1:0] != 2'b00));
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word RAM with per-lane write enables and a registered read port; no reset.
module mem_array #(
    parameter int unsigned DEPTH_WORDS = 256,
    localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Lane-masked write or registered read; read data holds until the next read.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int i = 0; i < 4; i++) begin
                    if (be_i[i]) begin
                        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one request per handshake, holds it for LATENCY cycles,
// then returns read data or a write acknowledge on a valid/ready response channel.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_wr_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [LAT_W-1:0] LatLoad = (LATENCY >= 2) ? LAT_W'(LATENCY - 2) : '0;

    state_e           state_q, state_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic             wr_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       be_q;
    logic             rsp_err_q;
    logic             rd_ok_q;

    logic             accept;
    logic             commit;
    logic             c_wr;
    logic [31:0]      c_addr;
    logic [31:0]      c_wdata;
    logic [3:0]       c_be;
    logic             c_err;
    logic [31:0]      ram_rdata;

    assign accept = (state_q == StIdle) && req_valid_i;

    // Next-state and counter; commit marks the single cycle that enters RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    if (LATENCY <= 1) begin
                        state_d = StResp;
                        commit  = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = LatLoad;
                    end
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StResp;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // With LATENCY=1 the commit happens in the accept cycle, before capture registers load.
    always_comb begin
        if (state_q == StIdle) begin
            c_wr    = req_wr_i;
            c_addr  = req_addr_i;
            c_wdata = req_wdata_i;
            c_be    = req_be_i;
        end else begin
            c_wr    = wr_q;
            c_addr  = addr_q;
            c_wdata = wdata_q;
            c_be    = be_q;
        end
        c_err = req_error(c_addr, c_be, DEPTH_WORDS);
    end

    // State, counter, captured request and registered response flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            rsp_err_q <= 1'b0;
            rd_ok_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wr_q    <= req_wr_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                be_q    <= req_be_i;
            end
            if (commit) begin
                rsp_err_q <= c_err;
                rd_ok_q   <= !c_wr && !c_err;
            end
        end
    end

    mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_mem_array (
        .clk_i  (clk_i),
        .en_i   (commit && !c_err),
        .we_i   (c_wr),
        .be_i   (c_be),
        .addr_i (c_addr[AW+1:2]),
        .wdata_i(c_wdata),
        .rdata_o(ram_rdata)
    );

    assign req_ready_o = (state_q == StIdle);
    assign rsp_valid_o = (state_q == StResp);
    assign rsp_err_o   = rsp_valid_o && rsp_err_q;
    // RAM read data is only meaningful for a successful read; everything else reports zero.
    assign rsp_rdata_o = (rsp_valid_o && rd_ok_q) ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (LATENCY 2, 4, 1) against a behavioural model.
module tb_mem_responder;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_wr    [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_be    [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_responder #(
            .DEPTH_WORDS(DEPTH),
            .LATENCY    ((g == 0) ? 2 : ((g == 1) ? 4 : 1))
        ) u_dut (
            .clk_i      (clk),
            .rst_ni     (rst_n),
            .req_valid_i(req_valid[g]),
            .req_ready_o(req_ready[g]),
            .req_wr_i   (req_wr[g]),
            .req_addr_i (req_addr[g]),
            .req_wdata_i(req_wdata[g]),
            .req_be_i   (req_be[g]),
            .rsp_valid_o(rsp_valid[g]),
            .rsp_ready_i(rsp_ready[g]),
            .rsp_rdata_o(rsp_rdata[g]),
            .rsp_err_o  (rsp_err[g])
        );
    end

    // One full transaction; returns response fields, latency (-1 on timeout) and ok, which
    // is low if the response wobbled during stall, req_ready rose early, or the handshake
    // did not return the DUT to idle.
    task automatic do_req(input int d, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input int stall,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output logic ok);
        int n;
        req_valid[d] = 1'b1;
        req_wr[d]    = wr;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = be;
        rsp_ready[d] = 1'b0;
        n = 0;
        while (!req_ready[d] && n < 50) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        // Inputs are don't-care after accept; scramble them, but keep req_valid high.
        req_wr[d]    = 1'($urandom);
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom;
        req_be[d]    = 4'($urandom);
        lat = 1;
        while (!rsp_valid[d] && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        if (!rsp_valid[d]) lat = -1;
        rdata = rsp_rdata[d];
        err   = rsp_err[d];
        ok    = rsp_valid[d] && !req_ready[d];
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            ok = ok && rsp_valid[d] && !req_ready[d] && (rsp_rdata[d] === rdata)
                 && (rsp_err[d] === err);
        end
        rsp_ready[d] = 1'b1;
        @(posedge clk); #1;
        ok = ok && !rsp_valid[d] && req_ready[d];
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rsp_valid[d] !== 1'b0 || rsp_err[d] !== 1'b0 || rsp_rdata[d] !== 32'h0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: valid=%b err=%b rdata=%h, want 0/0/0",
                         d, rsp_valid[d], rsp_err[d], rsp_rdata[d]);
            end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (req_ready[d] !== 1'b1) begin
                errors++;
                $display("FAIL reset_ready dut%0d: req_ready=%b, want 1", d, req_ready[d]);
            end
        end
        // rsp_ready outside RESP must do nothing.
        for (int d = 0; d < 3; d++) rsp_ready[d] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
                errors++;
                $display("FAIL idle_rsp_ready dut%0d: valid=%b ready=%b, want 0/1",
                         d, rsp_valid[d], req_ready[d]);
            end
            rsp_ready[d] = 1'b0;
        end
    endtask

    task automatic test_basic();
        logic [31:0] rd; logic er; int lat; logic ok;
        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat, ok);
        checks++;
        if (lat !== 2 || er !== 1'b0 || rd !== 32'h0 || !ok) begin
            errors++;
            $display("FAIL basic_write: lat=%0d err=%b rdata=%h ok=%b, want 2/0/0/1",
                     lat, er, rd, ok);
        end
        do_req(0, 1'b0, 32'h10, 32'h0, 4'hF, 0, rd, er, lat, ok);
        checks++;
        if (lat !== 2 || er !== 1'b0 || rd !== 32'hDEADBEEF || !ok) begin
            errors++;
            $display("FAIL basic_read: lat=%0d err=%b rdata=%h ok=%b, want 2/0/deadbeef/1",
                     lat, er, rd, ok);
        end
    endtask

    task automatic test_byte_write();
        logic [31:0] rd; logic er; int lat; logic ok;
        do_req(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd, er, lat, ok);
        do_req(0, 1'b1, 32'h20, 32'h77AA5566, 4'b0100, 0, rd, er, lat, ok);
        checks++;
        if (er !== 1'b0 || !ok) begin
            errors++;
            $display("FAIL byte_write_rsp: err=%b ok=%b, want 0/1", er, ok);
        end
        do_req(0, 1'b0, 32'h20, 32'h0, 4'hF, 0, rd, er, lat, ok);
        checks++;
        if (rd !== 32'h11AA3344 || er !== 1'b0) begin
            errors++;
            $display("FAIL byte_write_read: rdata=%h err=%b, want 11aa3344/0", rd, er);
        end
        // Sub-word read at an unaligned address returns the whole word without error.
        do_req(0, 1'b0, 32'h21, 32'h0, 4'b0010, 0, rd, er, lat, ok);
        checks++;
        if (rd !== 32'h11AA3344 || er !== 1'b0) begin
            errors++;
            $display("FAIL subword_read: rdata=%h err=%b, want 11aa3344/0", rd, er);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat; logic ok;
        do_req(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 0, rd, er, lat, ok);
        do_req(0, 1'b0, 32'h12, 32'h0, 4'hF, 0, rd, er, lat, ok);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0 || lat !== 2) begin
            errors++;
            $display("FAIL err_misaligned_read: err=%b rdata=%h lat=%0d, want 1/0/2", er, rd, lat);
        end
        do_req(0, 1'b1, 32'h12, 32'h01010101, 4'hF, 0, rd, er, lat, ok);
        checks++;
        if (er !== 1'b1) begin
            errors++;
            $display("FAIL err_misaligned_write: err=%b, want 1", er);
        end
        do_req(0, 1'b1, 32'h10, 32'h12345678, 4'h0, 0, rd, er, lat, ok);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL err_be_zero: err=%b rdata=%h, want 1/0", er, rd);
        end
        do_req(0, 1'b0, 32'h10, 32'h0, 4'hF, 0, rd, er, lat, ok);
        checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
            errors++;
            $display("FAIL err_word_unchanged: rdata=%h err=%b, want deadbeef/0", rd, er);
        end
        do_req(0, 1'b1, 32'(4 * DEPTH), 32'h12345678, 4'hF, 0, rd, er, lat, ok);
        checks++;
        if (er !== 1'b1 || lat !== 2 || !ok) begin
            errors++;
            $display("FAIL err_out_of_range: err=%b lat=%0d ok=%b, want 1/2/1", er, lat, ok);
        end
        do_req(0, 1'b0, 32'h0, 32'h0, 4'hF, 0, rd, er, lat, ok);
        checks++;
        if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
            errors++;
            $display("FAIL err_no_alias: rdata=%h err=%b, want cafef00d/0", rd, er);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat; logic ok;
        do_req(0, 1'b0, 32'h10, 32'h0, 4'hF, 5, rd, er, lat, ok);
        checks++;
        if (!ok || rd !== 32'hDEADBEEF || lat !== 2) begin
            errors++;
            $display("FAIL backpressure: ok=%b rdata=%h lat=%0d, want 1/deadbeef/2", ok, rd, lat);
        end
    endtask

    task automatic test_latency(input int d, input int want);
        logic [31:0] rd; logic er; int lat; logic ok;
        do_req(d, 1'b1, 32'h30, 32'h01020304, 4'hF, 1, rd, er, lat, ok);
        checks++;
        if (lat !== want || !ok || er !== 1'b0) begin
            errors++;
            $display("FAIL latency_write dut%0d: lat=%0d ok=%b err=%b, want %0d/1/0",
                     d, lat, ok, er, want);
        end
        do_req(d, 1'b0, 32'h30, 32'h0, 4'hF, 2, rd, er, lat, ok);
        checks++;
        if (lat !== want || !ok || rd !== 32'h01020304) begin
            errors++;
            $display("FAIL latency_read dut%0d: lat=%0d ok=%b rdata=%h, want %0d/1/01020304",
                     d, lat, ok, rd, want);
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] rd; logic er; int lat; logic ok; int n;
        // Pulse reset while a LATENCY=4 write sits in WAIT: the write must never happen.
        req_valid[1] = 1'b1; req_wr[1] = 1'b1; req_addr[1] = 32'h30;
        req_wdata[1] = 32'h5555AAAA; req_be[1] = 4'hF; rsp_ready[1] = 1'b0;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        checks++;
        if (rsp_valid[1] !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset_valid: rsp_valid=%b, want 0", rsp_valid[1]);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
            errors++;
            $display("FAIL midop_dropped: valid=%b ready=%b, want 0/1", rsp_valid[1], req_ready[1]);
        end
        do_req(1, 1'b0, 32'h30, 32'h0, 4'hF, 0, rd, er, lat, ok);
        checks++;
        if (rd !== 32'h01020304 || er !== 1'b0) begin
            errors++;
            $display("FAIL midop_old_word: rdata=%h err=%b, want 01020304/0", rd, er);
        end
        // Reset while in RESP: the write has committed and must persist.
        do_req(1, 1'b1, 32'h34, 32'h0BADF00D, 4'hF, 0, rd, er, lat, ok);
        req_valid[1] = 1'b1; req_wr[1] = 1'b1; req_addr[1] = 32'h34;
        req_wdata[1] = 32'hA5A5A5A5; req_be[1] = 4'hF;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        n = 0;
        while (!rsp_valid[1] && n < 20) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (rsp_valid[1] !== 1'b1) begin
            errors++;
            $display("FAIL resp_reset_reach: rsp_valid=%b, want 1", rsp_valid[1]);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_req(1, 1'b0, 32'h34, 32'h0, 4'hF, 0, rd, er, lat, ok);
        checks++;
        if (rd !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL resp_reset_persist: rdata=%h, want a5a5a5a5", rd);
        end
    endtask

    task automatic test_random();
        logic [31:0] model [DEPTH];
        logic [31:0] rd, addr, wdata, exp_rd;
        logic [3:0]  be;
        logic        er, ok, wr, exp_err;
        int          lat, stall;
        int unsigned idx;
        for (int i = 0; i < DEPTH; i++) begin
            model[i] = $urandom;
            do_req(0, 1'b1, 32'(i * 4), model[i], 4'hF, 0, rd, er, lat, ok);
            checks++;
            if (er !== 1'b0 || lat !== 2 || !ok) begin
                errors++;
                $display("FAIL rand_init word %0d: err=%b lat=%0d ok=%b, want 0/2/1",
                         i, er, lat, ok);
            end
        end
        for (int t = 0; t < 300; t++) begin
            wr    = 1'($urandom);
            wdata = $urandom;
            be    = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
            if ($urandom_range(0, 9) == 0) addr = 32'(4 * DEPTH + $urandom_range(0, 1023));
            else addr = 32'($urandom_range(0, 4 * DEPTH - 1));
            stall = $urandom_range(0, 3);
            idx = addr / 4;
            exp_err = (idx >= DEPTH) || (be == 4'h0) || (be == 4'hF && (addr % 4) != 0);
            exp_rd = 32'h0;
            if (!exp_err) begin
                if (wr) begin
                    for (int l = 0; l < 4; l++) begin
                        if (be[l]) model[idx][8*l +: 8] = wdata[8*l +: 8];
                    end
                end else begin
                    exp_rd = model[idx];
                end
            end
            do_req(0, wr, addr, wdata, be, stall, rd, er, lat, ok);
            checks++;
            if (rd !== exp_rd || er !== exp_err || lat !== 2 || !ok) begin
                errors++;
                $display("FAIL rand op %0d wr=%b addr=%h be=%h: rdata=%h err=%b lat=%0d ok=%b, want %h/%b/2/1",
                         t, wr, addr, be, rd, er, lat, ok, exp_rd, exp_err);
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            req_valid[d] = 1'b0; req_wr[d] = 1'b0; req_addr[d] = '0;
            req_wdata[d] = '0; req_be[d] = '0; rsp_ready[d] = 1'b0;
        end
        test_reset();
        test_basic();
        test_byte_write();
        test_errors();
        test_backpressure();
        test_latency(1, 4);
        test_latency(2, 1);
        test_reset_midop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
